// File: rtl/prio_encoder_rr_pkg.sv
// enc_pkg: shared mode constants, request classification and lowest-set-bit helpers.
package enc_pkg;
  localparam int ENC_MODE_FIXED = 0;
  localparam int ENC_MODE_RR = 1;
  typedef enum logic [1:0] {ENC_NONE, ENC_ONE, ENC_MULTI} enc_class_t;
  function automatic logic [5:0] lsb_index(input logic [63:0] vec);
    logic [5:0] r;
    r = '0;
    for (int i = 63; i >= 0; i--) if (vec[i]) r = 6'(i);
    return r;
  endfunction
  function automatic enc_class_t popcnt_class(input logic [63:0] vec);
    return vec == '0 ? ENC_NONE : (vec & (vec - 64'd1)) == '0 ? ENC_ONE : ENC_MULTI;
  endfunction
endpackage

// File: rtl/prio_encoder_rr_pick.sv
// rr_prio_pick: round-robin pick, first set bit above ptr, else lowest set bit.
module rr_prio_pick
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [N-1:0] masked;
  for (genvar i = 0; i < N; i++) begin : g_mask
    assign masked[i] = req[i] & (W'(i) > ptr);
  end
  assign idx = W'(lsb_index(64'(|masked ? masked : req)));
  assign any = |req;
endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-to-log2(N) fixed/round-robin priority encoder with a registered valid/ready output.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int MODE = ENC_MODE_FIXED,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_onehot,
  output logic         out_multi,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] rr_ptr, rr_idx, idx;
  logic rr_any;
  enc_class_t cls;
  rr_prio_pick #(.N(N), .W(W)) u_pick (
    .req(in_req),
    .ptr(rr_ptr),
    .idx(rr_idx),
    .any(rr_any)
  );
  always_comb begin
    idx = MODE == ENC_MODE_RR ? rr_idx : W'(lsb_index(64'(in_req)));
    cls = popcnt_class(64'(in_req));
  end
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx <= '0;
      out_none <= 1'b0;
      out_onehot <= 1'b0;
      out_multi <= 1'b0;
      rr_ptr <= W'(N - 1);
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_idx <= idx;
      out_none <= cls == ENC_NONE;
      out_onehot <= cls == ENC_ONE;
      out_multi <= cls == ENC_MULTI;
      if (rr_any) rr_ptr <= rr_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: fixed and round-robin instances driven together against a per-mode reference model.
module tb_prio_encoder_rr;
  localparam int N = 8;
  localparam int W = 3;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0;
  logic v = 0, ordy = 0;
  logic r0, r1, v0, v1, n0, n1, h0, h1, m0, m1;
  logic [W-1:0] i0, i1;
  int n_cmp = 0, n_bad = 0;
  int mv[2], midx[2], mfl[2], mptr[2];

  prio_encoder_rr #(.N(N), .MODE(0)) u0 (.clk(clk), .rst(rst), .in_req(req), .in_valid(v), .in_ready(r0),
    .out_idx(i0), .out_none(n0), .out_onehot(h0), .out_multi(m0), .out_valid(v0), .out_ready(ordy));
  prio_encoder_rr #(.N(N), .MODE(1)) u1 (.clk(clk), .rst(rst), .in_req(req), .in_valid(v), .in_ready(r1),
    .out_idx(i1), .out_none(n1), .out_onehot(h1), .out_multi(m1), .out_valid(v1), .out_ready(ordy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input logic [N-1:0] r, input int p);
    if (r == '0) return 0;
    if (mode == 0) begin
      for (int j = 0; j < N; j++) if (r[j]) return j;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic int flags(input logic [N-1:0] r);
    int c = 0;
    for (int j = 0; j < N; j++) c += int'(r[j]);
    return c == 0 ? 1 : c == 1 ? 2 : 4;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mv[m] = 0; midx[m] = 0; mfl[m] = 0; mptr[m] = N - 1;
      end else if (v && (mv[m] == 0 || ordy)) begin
        midx[m] = pick(m, req, mptr[m]);
        mfl[m] = flags(req);
        if (req != '0) mptr[m] = midx[m];
        mv[m] = 1;
      end else if (ordy) mv[m] = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic vv, input logic oo);
    req = r; v = vv; ordy = oo;
    #1;
    chk("in_ready0", 32'(r0), (mv[0] == 0 || oo) ? 1 : 0);
    chk("in_ready1", 32'(r1), (mv[1] == 0 || oo) ? 1 : 0);
    @(posedge clk);
    model_edge();
    #1;
    chk("valid0", 32'(v0), mv[0]);
    chk("idx0", 32'(i0), midx[0]);
    chk("flags0", 32'({m0, h0, n0}), mfl[0]);
    chk("valid1", 32'(v1), mv[1]);
    chk("idx1", 32'(i1), midx[1]);
    chk("flags1", 32'({m1, h1, n1}), mfl[1]);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [7:0] seq[4];
    int exp_idx[4];
    seq = '{8'h01, 8'h02, 8'h04, 8'h80};
    exp_idx = '{0, 1, 2, 7};
    #2;
    rst = 1;
    step(8'hFF, 1, 1);
    step(8'hFF, 1, 1);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_outs", 32'({i0, n0, h0, m0}), 0);
    rst = 0;
    step(8'h01, 1, 1);
    chk("first_valid", 32'(v0), 1);
    for (int k = 0; k < 4; k++) begin
      step(seq[k], 1, 1);
      chk("legacy_idx", 32'(i0), exp_idx[k]);
      chk("legacy_onehot", 32'(h0), 1);
    end
    step(8'h00, 1, 1);
    chk("zero_idx", 32'(i0), 0);
    chk("zero_none", 32'(n0), 1);
    step(8'hA4, 1, 1);
    chk("prio_idx", 32'(i0), 2);
    chk("prio_multi", 32'(m0), 1);
    rst = 1;
    step(8'h00, 0, 1);
    rst = 0;
    exp_idx = '{0, 4, 7, 0};
    for (int k = 0; k < 4; k++) begin
      step(8'h91, 1, 1);
      chk("rr_idx", 32'(i1), exp_idx[k]);
    end
    step(8'h00, 1, 1);
    chk("rr_none", 32'(n1), 1);
    step(8'h91, 1, 1);
    chk("rr_keep_ptr", 32'(i1), 4);
    step(8'h10, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step(8'h01, 1, 0);
      chk("bp_ready", 32'(r0), 0);
      chk("bp_idx", 32'(i0), 4);
      chk("bp_valid", 32'(v0), 1);
    end
    step(8'h01, 1, 1);
    chk("bp_release", 32'(i0), 0);
    chk("bp_nobubble", 32'(v0), 1);
    step(8'h02, 1, 1);
    step(8'h02, 1, 0);
    rst = 1;
    step(8'hFF, 1, 0);
    rst = 0;
    chk("midrst_valid", 32'(v1), 0);
    step(8'hFF, 1, 1);
    chk("midrst_rr", 32'(i1), 0);
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(N - 1);
        default: r = N'($urandom);
      endcase
      rst = $urandom_range(99) == 0;
      step(r, $urandom_range(3) != 0, $urandom_range(2) != 0);
      rst = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
Parametrised N-to-log2(N) encoder, successor to the team's fixed 4-to-2 one-hot encoder. It accepts arbitrary (not only one-hot) request vectors and selects one index by fixed-LSB priority or round-robin. The result is registered behind a valid/ready handshake. It sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
N, 8, number of request inputs; legal range 2..64.
MODE, 0, selection mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
W, max(1,$clog2(N)), localparam; width of the index output (not overridable).

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_req  input  N  request vector, one bit per source
in_valid  input  1  in_req is valid this cycle
in_ready  output  1  block can capture in_req this cycle
out_idx  output  W  selected index
out_none  output  1  captured vector was all-zero
out_onehot  output  1  captured vector had exactly one bit set (legacy "valid" meaning)
out_multi  output  1  captured vector had two or more bits set
out_valid  output  1  out_* fields hold a result
out_ready  input  1  consumer accepts the result

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values (sampled on the clk edge with rst=1): out_valid=0, out_idx=0, out_none=0, out_onehot=0, out_multi=0, rr_ptr=N-1. rst overrides all other inputs.
- Reset mid-operation: any held result is discarded, with no handshake completion.
- in_ready = !out_valid || out_ready. This is combinational with no dependence on in_valid.
- Capture: on an edge with in_valid && in_ready, the output register loads the new result.
  - out_valid becomes 1.
  - Latency is 1 cycle from capture to out_valid.
- Hold: while out_valid && !out_ready, all out_* fields are stable and in_req is ignored.
- Drain: on out_valid && out_ready && !(in_valid && in_ready), out_valid goes to 0. Data fields keep their last values.
- Simultaneous drain and capture: the new result replaces the old one on the same edge and out_valid stays 1. This gives full throughput of 1 result per cycle.
- Flags: exactly one of out_none, out_onehot, out_multi is 1 whenever out_valid=1.
- All-zero vector: out_idx=0, out_none=1. It is still presented as a result. rr_ptr is unchanged.
- MODE=0: out_idx is the lowest set bit index. One-hot inputs map exactly as the legacy encoder did (bit k gives k).
- MODE=1: the search starts at rr_ptr+1 and wraps modulo N.
  - Implementation: form masked = in_req with bits 0..rr_ptr cleared. If masked is nonzero, pick its lowest set bit; otherwise pick the lowest set bit of in_req.
  - rr_ptr updates to the picked index on every capture with a nonzero in_req.
  - With rr_ptr=N-1 the mask is empty, so the search starts at bit 0.
- MODE=0: rr_ptr is unused and may be optimised away.
- Arithmetic: index comparisons are unsigned and W bits wide. If N is not a power of 2, indices >= N are never produced.
- X-safety: out_* fields are don't-care while out_valid=0, but must never be X after reset.

Decomposition:
- Package enc_pkg holds:
  - localparams ENC_MODE_FIXED=0 and ENC_MODE_RR=1;
  - function lsb_index(vec) returning the lowest set index, or 0 for an all-zero vector;
  - function popcnt_class(vec) returning none/one/multi as a 2-bit enum enc_class_t.
- One combinational sub-module, rr_prio_pick (N, rr_ptr, in_req -> idx, any), does the masked two-pass search. The top level holds the output register, the handshake and rr_ptr.

Test Plan (N=8):
1. Reset with MODE=0: assert rst 2 cycles with in_valid=1 and in_req=8'hFF -> out_valid=0 and all outputs 0 throughout. After release, the first capture gives out_valid=1 one cycle later.
2. Legacy mapping with MODE=0: drive in_req=8'h01, 8'h02, 8'h04, 8'h80 back-to-back with out_ready=1 -> out_idx=0,1,2,7 on consecutive cycles with out_onehot=1. Then drive 8'h00 -> out_idx=0 and out_none=1.
3. Priority with MODE=0: drive in_req=8'hA4 -> out_idx=2 and out_multi=1.
4. Round-robin with MODE=1: hold in_req=8'h91 for 4 captures -> out_idx=0,4,7,0. Then drive 8'h00 -> out_none=1, and a following 8'h91 gives idx=4 (pointer unchanged by the all-zero vector).
5. Backpressure: capture 8'h10, then hold out_ready=0 for 3 cycles while in_req=8'h01 -> in_ready=0, out_idx stays 4, out_valid stays 1. Raising out_ready with in_valid=1 gives out_idx=0 on the next edge with no bubble.
6. Reset mid-hold: out_valid=1 stalled, assert rst for 1 cycle -> out_valid=0 on the next edge. A subsequent MODE=1 capture of 8'hFF gives idx=0 (rr_ptr was reset).
